// File: rtl/sprite_mover.sv
// Moves a square sprite on a 640x480 VGA raster from pushbuttons, once per frame,
// and paints sprite, screen border and background into registered RGB outputs.
module sprite_mover #(
  parameter logic [9:0] X0    = 10'd312,
  parameter logic [9:0] Y0    = 10'd232,
  parameter logic [9:0] SIZE  = 10'd16,
  parameter logic [9:0] STEP  = 10'd2,
  parameter logic [9:0] COLOR = 10'h3FF
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic       iLEFT_N,
  input  logic       iRIGHT_N,
  input  logic       iUP_N,
  input  logic       iDOWN_N,
  input  logic       iCLR,
  output logic [9:0] oRed,
  output logic [9:0] oGreen,
  output logic [9:0] oBlue,
  output logic       oHIT,
  output logic [7:0] oMOVES
);

  localparam logic [9:0] XMAX = 10'd640 - SIZE;
  localparam logic [9:0] YMAX = 10'd480 - SIZE;

  // Button order in the vectors: {left, right, up, down}, active-low.
  logic [3:0] btn_s1_q, btn_s2_q;
  logic [9:0] py_prev_q;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [7:0] moves_q, moves_d;
  logic       hit_q, hit_d;
  logic [9:0] red_d, green_d, blue_d;
  logic [9:0] nx, ny;
  logic       tick;
  logic       in_sprite, in_border, visible;
  logic [3:0] pressed;

  // Moves one axis by STEP and clamps to [0, lim]; opposing buttons cancel.
  function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic inc,
                                           input logic dec, input logic [9:0] lim);
    logic [10:0] sum;
    sum = {1'b0, pos} + {1'b0, STEP};
    step_axis = pos;
    if (inc && !dec)
      step_axis = (sum > {1'b0, lim}) ? lim : sum[9:0];
    else if (dec && !inc)
      step_axis = (pos < STEP) ? 10'd0 : pos - STEP;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign pressed = ~btn_s2_q;
  assign tick    = (py == 10'd480) && (py_prev_q != 10'd480);
  assign nx      = step_axis(x_q, pressed[2], pressed[3], XMAX);
  assign ny      = step_axis(y_q, pressed[0], pressed[1], YMAX);

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    moves_d = moves_q;
    hit_d   = hit_q;
    if (iCLR) begin
      x_d     = X0;
      y_d     = Y0;
      moves_d = 8'd0;
      hit_d   = 1'b0;
    end else if (tick) begin
      x_d   = nx;
      y_d   = ny;
      hit_d = (nx == 10'd0) || (nx == XMAX) || (ny == 10'd0) || (ny == YMAX);
      if ((nx != x_q) || (ny != y_q))
        moves_d = sat_inc(moves_q);
    end
  end

  // Position only changes at the tick in vertical blanking, so a visible frame never tears.
  always_comb begin
    visible   = (px < 10'd640) && (py < 10'd480);
    in_sprite = ({1'b0, px} >= {1'b0, x_q}) && ({1'b0, px} < ({1'b0, x_q} + {1'b0, SIZE})) &&
                ({1'b0, py} >= {1'b0, y_q}) && ({1'b0, py} < ({1'b0, y_q} + {1'b0, SIZE}));
    in_border = (px < 10'd4) || (px >= 10'd636) || (py < 10'd4) || (py >= 10'd476);
    red_d     = 10'd0;
    green_d   = 10'd0;
    blue_d    = 10'd0;
    if (visible) begin
      if (in_sprite) begin
        red_d   = COLOR;
        green_d = COLOR;
      end else if (in_border) begin
        blue_d  = 10'h3FF;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      btn_s1_q  <= 4'hF;
      btn_s2_q  <= 4'hF;
      py_prev_q <= 10'd0;
      x_q       <= X0;
      y_q       <= Y0;
      moves_q   <= 8'd0;
      hit_q     <= 1'b0;
      oRed      <= 10'd0;
      oGreen    <= 10'd0;
      oBlue     <= 10'd0;
    end else begin
      btn_s1_q  <= {iLEFT_N, iRIGHT_N, iUP_N, iDOWN_N};
      btn_s2_q  <= btn_s1_q;
      py_prev_q <= py;
      x_q       <= x_d;
      y_q       <= y_d;
      moves_q   <= moves_d;
      hit_q     <= hit_d;
      oRed      <= red_d;
      oGreen    <= green_d;
      oBlue     <= blue_d;
    end
  end

  assign oHIT   = hit_q;
  assign oMOVES = moves_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: compressed frames (py jumps to 480 for one cycle),
// a frame-level position model, colour table vectors and randomized traffic.
module tb_sprite_mover;
  logic       iCLK = 1'b0;
  logic       iRST;
  logic [9:0] px, py;
  logic       iLEFT_N, iRIGHT_N, iUP_N, iDOWN_N, iCLR;
  logic [9:0] oRed, oGreen, oBlue;
  logic       oHIT;
  logic [7:0] oMOVES;

  localparam int SZ = 16;
  localparam int STP = 2;
  localparam logic [29:0] SPR = {10'h3FF, 10'h3FF, 10'd0};
  localparam logic [29:0] BLU = {10'd0, 10'd0, 10'h3FF};
  localparam logic [29:0] BLK = 30'd0;

  sprite_mover dut (
    .iCLK(iCLK), .iRST(iRST), .px(px), .py(py),
    .iLEFT_N(iLEFT_N), .iRIGHT_N(iRIGHT_N), .iUP_N(iUP_N), .iDOWN_N(iDOWN_N),
    .iCLR(iCLR), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oHIT(oHIT), .oMOVES(oMOVES)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;
  int mx, my, mmoves;
  bit mhit;

  typedef struct {
    int          x;
    int          y;
    logic [29:0] e;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge iCLK);
    #1;
  endtask

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [29:0] expc(int x, int y, int sx, int sy);
    if (x >= 640 || y >= 480) return BLK;
    if (x >= sx && x < sx + SZ && y >= sy && y < sy + SZ) return SPR;
    if (x < 4 || x >= 636 || y < 4 || y >= 476) return BLU;
    return BLK;
  endfunction

  task automatic model_reset();
    mx = 312; my = 232; mmoves = 0; mhit = 0;
  endtask

  task automatic model_frame(input bit l, input bit r, input bit u, input bit d, input bit clr);
    int dx, dy, nx, ny;
    if (clr) begin
      model_reset();
    end else begin
      dx = (r && !l) ? STP : ((l && !r) ? -STP : 0);
      dy = (d && !u) ? STP : ((u && !d) ? -STP : 0);
      nx = clampi(mx + dx, 0, 640 - SZ);
      ny = clampi(my + dy, 0, 480 - SZ);
      if ((nx != mx || ny != my) && mmoves < 255) mmoves++;
      mhit = (nx == 0) || (nx == 640 - SZ) || (ny == 0) || (ny == 480 - SZ);
      mx = nx;
      my = ny;
    end
  endtask

  task automatic set_btn(input bit l, input bit r, input bit u, input bit d);
    iLEFT_N = !l; iRIGHT_N = !r; iUP_N = !u; iDOWN_N = !d;
  endtask

  task automatic frame(input bit clr);
    px = 10'd0;
    py = 10'd479;
    repeat (3) cyc();
    py   = 10'd480;
    iCLR = clr;
    model_frame(!iLEFT_N, !iRIGHT_N, !iUP_N, !iDOWN_N, clr);
    cyc();
    iCLR = 1'b0;
    py   = 10'd0;
    cyc();
    chk("moves", oMOVES, mmoves);
    chk("hit", oHIT, mhit);
  endtask

  task automatic probe(input string nm, input int x, input int y);
    px = x[9:0];
    py = y[9:0];
    cyc();
    chk(nm, {oRed, oGreen, oBlue}, expc(x, y, mx, my));
  endtask

  task automatic probes();
    probe("pos_tl", mx, my);
    probe("pos_br", mx + SZ - 1, my + SZ - 1);
    probe("pos_r", mx + SZ, my);
    if (mx > 0) probe("pos_l", mx - 1, my);
    if (my > 0) probe("pos_up", mx, my - 1);
  endtask

  initial begin
    tbl[0]  = '{312, 232, SPR};  tbl[1]  = '{327, 247, SPR};
    tbl[2]  = '{328, 232, BLK};  tbl[3]  = '{311, 232, BLK};
    tbl[4]  = '{312, 248, BLK};  tbl[5]  = '{2, 100, BLU};
    tbl[6]  = '{639, 10, BLU};   tbl[7]  = '{636, 300, BLU};
    tbl[8]  = '{635, 300, BLK};  tbl[9]  = '{100, 3, BLU};
    tbl[10] = '{100, 4, BLK};    tbl[11] = '{100, 479, BLU};
    tbl[12] = '{100, 476, BLU};  tbl[13] = '{100, 475, BLK};
    tbl[14] = '{640, 0, BLK};    tbl[15] = '{700, 10, BLK};
    tbl[16] = '{320, 500, BLK};

    iRST = 1'b1; px = 10'd0; py = 10'd0; iCLR = 1'b0;
    set_btn(0, 0, 0, 0);
    repeat (2) cyc();
    chk("rst_rgb", {oRed, oGreen, oBlue}, BLK);
    chk("rst_moves", oMOVES, 0);
    chk("rst_hit", oHIT, 0);
    iRST = 1'b0;
    model_reset();

    // Idle frames after reset.
    repeat (3) begin
      frame(0);
      probes();
    end
    chk("idle_moves", oMOVES, 8'd0);

    for (int i = 0; i < 17; i++) begin
      px = tbl[i].x[9:0];
      py = tbl[i].y[9:0];
      cyc();
      chk($sformatf("tbl%0d", i), {oRed, oGreen, oBlue}, tbl[i].e);
    end

    // Right for 10 frames.
    set_btn(0, 1, 0, 0);
    repeat (10) frame(0);
    chk("right_moves", oMOVES, 8'd10);
    px = 10'd332; py = 10'd232;
    cyc();
    chk("right_px332", {oRed, oGreen, oBlue}, SPR);
    probes();

    // Left and right together cancel.
    set_btn(1, 1, 0, 0);
    repeat (5) frame(0);
    chk("both_moves", oMOVES, 8'd10);
    probes();

    // Left into the clamp from a cleared state.
    set_btn(0, 0, 0, 0);
    frame(1);
    set_btn(1, 0, 0, 0);
    for (int i = 1; i <= 200; i++) begin
      frame(0);
      if (i == 155) chk("left155_hit", oHIT, 1'b0);
      if (i == 156) chk("left156_moves", oMOVES, 8'd156);
    end
    chk("left_moves", oMOVES, 8'd156);
    chk("left_hit", oHIT, 1'b1);
    px = 10'd0; py = 10'd232;
    cyc();
    chk("left_px0", {oRed, oGreen, oBlue}, SPR);
    probes();

    // Clear wins over a simultaneous tick with down held.
    set_btn(0, 0, 0, 1);
    frame(1);
    chk("clr_moves", oMOVES, 8'd0);
    chk("clr_hit", oHIT, 1'b0);
    probes();
    px = 10'd2; py = 10'd100;
    cyc();
    chk("clr_border", {oRed, oGreen, oBlue}, BLU);
    px = 10'd700; py = 10'd10;
    cyc();
    chk("clr_offscreen", {oRed, oGreen, oBlue}, BLK);

    // Down into the bottom clamp.
    repeat (300) frame(0);
    chk("down_moves", oMOVES, 8'd116);
    chk("down_hit", oHIT, 1'b1);
    px = 10'd312; py = 10'd464;
    cyc();
    chk("down_py464", {oRed, oGreen, oBlue}, SPR);
    probes();

    // Randomized frames.
    for (int i = 0; i < 150; i++) begin
      int rx, ry;
      set_btn($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      frame($urandom_range(0, 19) == 0);
      probes();
      rx = $urandom_range(0, 799);
      ry = $urandom_range(0, 524);
      if (ry == 480) ry = 481;
      probe("rnd_px", rx, ry);
    end

    // Asynchronous reset mid-frame, released on a py==480 cycle.
    set_btn(0, 1, 0, 0);
    px = 10'd0; py = 10'd479;
    repeat (2) cyc();
    #2;
    iRST = 1'b1;
    #1;
    chk("arst_moves", oMOVES, 8'd0);
    chk("arst_hit", oHIT, 1'b0);
    chk("arst_rgb", {oRed, oGreen, oBlue}, BLK);
    model_reset();
    py = 10'd480;
    cyc();
    iRST = 1'b0;
    model_frame(0, 0, 0, 0, 0);
    repeat (3) cyc();
    py = 10'd0;
    cyc();
    chk("arst_after_moves", oMOVES, mmoves);
    probes();
    frame(0);
    chk("arst_resume_moves", oMOVES, 8'd1);
    probes();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
